// File: rtl/gpu_pkg.sv
// Shared pixel field layout, clear FSM encoding and default screen size for the framebuffer path.
// Pure definitions: no latency, no flow control.
package gpu_pkg;

    localparam int PX_X_HI   = 63;
    localparam int PX_Y_HI   = 47;
    localparam int PX_COL_HI = 31;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Full-screen fill sequencer: emits addresses 0..H_RES*V_RES-1 with a latched colour.
// The address advances only on ack, so a stalled write port freezes the sweep.
module fb_clear_engine
    import gpu_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           start_colour,
    input  logic                  ack,
    output logic                  req,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           colour
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);

    clr_state_t            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           colour_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= CLR_IDLE;
            addr_q   <= '0;
            colour_q <= '0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (start) begin
                        state_q  <= CLR_RUN;
                        addr_q   <= '0;
                        colour_q <= start_colour;
                    end
                end
                CLR_RUN: begin
                    if (ack) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= CLR_IDLE;
                        end
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign req    = (state_q == CLR_RUN);
    assign addr   = addr_q;
    assign colour = colour_q;

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates two pixel streams and the clear engine onto one framebuffer write port, clipping off-screen pixels.
// Accept-to-write latency 1; srcN_full asserts while clearing, while the output stage is stalled, or when not granted.
module fb_write_scheduler
    import gpu_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [63:0]           src0_data,
    input  logic                  src0_valid,
    output logic                  src0_full,
    input  logic [63:0]           src1_data,
    input  logic                  src1_valid,
    output logic                  src1_full,
    input  logic                  clear_start,
    input  logic [31:0]           clear_colour,
    output logic                  clear_busy,
    output logic [ADDR_WIDTH-1:0] fb_address,
    output logic [31:0]           fb_writedata,
    output logic                  fb_write,
    input  logic                  fb_waitrequest,
    output logic [15:0]           clip_count,
    output logic                  idle
);

    localparam logic [15:0]           X_LIM   = 16'(H_RES);
    localparam logic [15:0]           Y_LIM   = 16'(V_RES);
    localparam logic [ADDR_WIDTH-1:0] H_RES_A = ADDR_WIDTH'(H_RES);

    logic                  fb_write_q, fb_write_d;
    logic [ADDR_WIDTH-1:0] fb_address_q, fb_address_d;
    logic [31:0]           fb_writedata_q, fb_writedata_d;
    logic                  rr_last_q, rr_last_d;
    logic [15:0]           clip_count_q, clip_count_d;

    logic                  out_free;
    logic                  clr_req, clr_ack;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [31:0]           clr_colour;
    logic                  grant0, grant1, accept, clipped;
    logic [63:0]           sel_data;
    logic [15:0]           sel_x, sel_y;
    logic [ADDR_WIDTH-1:0] pix_addr;

    fb_clear_engine #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (clear_start),
        .start_colour (clear_colour),
        .ack          (clr_ack),
        .req          (clr_req),
        .addr         (clr_addr),
        .colour       (clr_colour)
    );

    assign out_free = !fb_write_q || !fb_waitrequest;

    // rr_last_q = 1 means src1 was granted last, so src0 takes a tie
    assign grant0 = src0_valid && (!src1_valid || rr_last_q);
    assign grant1 = src1_valid && (!src0_valid || !rr_last_q);

    assign src0_full = clr_req || !out_free || !grant0;
    assign src1_full = clr_req || !out_free || !grant1;

    assign accept   = (grant0 || grant1) && out_free && !clr_req;
    assign clr_ack  = clr_req && out_free;
    assign sel_data = grant0 ? src0_data : src1_data;
    assign sel_x    = sel_data[PX_X_HI -: 16];
    assign sel_y    = sel_data[PX_Y_HI -: 16];
    assign clipped  = (sel_x >= X_LIM) || (sel_y >= Y_LIM);
    assign pix_addr = ADDR_WIDTH'(sel_y) * H_RES_A + ADDR_WIDTH'(sel_x);

    always_comb begin
        fb_write_d     = fb_write_q;
        fb_address_d   = fb_address_q;
        fb_writedata_d = fb_writedata_q;
        rr_last_d      = rr_last_q;
        clip_count_d   = clip_count_q;

        if (clr_ack) begin
            fb_write_d     = 1'b1;
            fb_address_d   = clr_addr;
            fb_writedata_d = clr_colour;
        end else if (accept && !clipped) begin
            fb_write_d     = 1'b1;
            fb_address_d   = pix_addr;
            fb_writedata_d = sel_data[PX_COL_HI -: 32];
        end else if (out_free) begin
            fb_write_d = 1'b0;
        end

        if (accept) begin
            rr_last_d = grant1;
            if (clipped && (clip_count_q != 16'hFFFF)) begin
                clip_count_d = clip_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fb_write_q     <= 1'b0;
            fb_address_q   <= '0;
            fb_writedata_q <= '0;
            rr_last_q      <= 1'b1;
            clip_count_q   <= '0;
        end else begin
            fb_write_q     <= fb_write_d;
            fb_address_q   <= fb_address_d;
            fb_writedata_q <= fb_writedata_d;
            rr_last_q      <= rr_last_d;
            clip_count_q   <= clip_count_d;
        end
    end

    assign fb_write     = fb_write_q;
    assign fb_address   = fb_address_q;
    assign fb_writedata = fb_writedata_q;
    assign clip_count   = clip_count_q;
    assign clear_busy   = clr_req;
    assign idle         = !clr_req && !fb_write_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler on a 10x6 screen: directed scenarios then randomized traffic.
// Stimulus side predicts writes into a queue; a separate monitor pops and compares every presented write.
module tb_fb_write_scheduler;

    localparam int H    = 10;
    localparam int V    = 6;
    localparam int AW   = 6;
    localparam int NPIX = H * V;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [63:0]   src0_data = '0, src1_data = '0;
    logic          src0_valid = 1'b0, src1_valid = 1'b0;
    logic          src0_full, src1_full;
    logic          clear_start = 1'b0;
    logic [31:0]   clear_colour = '0;
    logic          clear_busy;
    logic [AW-1:0] fb_address;
    logic [31:0]   fb_writedata;
    logic          fb_write;
    logic          fb_waitrequest = 1'b0;
    logic [15:0]   clip_count;
    logic          idle;

    fb_write_scheduler #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .src0_data      (src0_data),
        .src0_valid     (src0_valid),
        .src0_full      (src0_full),
        .src1_data      (src1_data),
        .src1_valid     (src1_valid),
        .src1_full      (src1_full),
        .clear_start    (clear_start),
        .clear_colour   (clear_colour),
        .clear_busy     (clear_busy),
        .fb_address     (fb_address),
        .fb_writedata   (fb_writedata),
        .fb_write       (fb_write),
        .fb_waitrequest (fb_waitrequest),
        .clip_count     (clip_count),
        .idle           (idle)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] col;
        bit          is_clr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] q0[$], q1[$];
    int          tests = 0, fails = 0;
    int          clr_rem = 0, clip_m = 0;
    bit          rr_m = 1'b1;
    int          lat_cyc = -10, lat_addr = 0;
    bit          prev_rst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] px(input int x, input int y, input logic [31:0] c);
        return {16'(x), 16'(y), c};
    endfunction

    function automatic logic [63:0] rand_px();
        return px($urandom_range(H + 1), $urandom_range(V + 1), $urandom);
    endfunction

    // Reference behaviour of one accepted pixel: on-screen pixels become a write at y*H+x
    function automatic void take(input logic [63:0] d, input bit src);
        int x = int'(d[63:48]);
        int y = int'(d[47:32]);
        rr_m = src;
        if (x < H && y < V) begin
            sb.push_back('{addr: y * H + x, col: d[31:0], is_clr: 1'b0});
            lat_cyc  = cyc;
            lat_addr = y * H + x;
        end else if (clip_m < 65535) begin
            clip_m++;
        end
    endfunction

    // wmode: 0 = waitrequest low, 1 = high, 2 = random
    task automatic step(input int wmode, input bit start, input bit rst);
        bit busy_e, g0, g1, wait_e;
        @(posedge clock);
        #2;
        reset_n      = !rst;
        src0_valid   = (q0.size() > 0);
        src0_data    = src0_valid ? q0[0] : rand_px();
        src1_valid   = (q1.size() > 0);
        src1_data    = src1_valid ? q1[0] : rand_px();
        clear_start  = start;
        clear_colour = $urandom;
        fb_waitrequest = (wmode == 2) ? ($urandom_range(3) == 0) : (wmode == 1);
        #4;
        if (!reset_n) begin
            sb.delete();
            clr_rem  = 0;
            clip_m   = 0;
            rr_m     = 1'b1;
            lat_cyc  = -10;
            prev_rst = 1'b1;
            return;
        end
        if (prev_rst) begin
            check("reset_fb_address", 64'(fb_address), 0);
            check("reset_fb_writedata", 64'(fb_writedata), 0);
            prev_rst = 1'b0;
        end
        busy_e = (clr_rem > 1);
        g0     = src0_valid && (!src1_valid || rr_m);
        g1     = src1_valid && (!src0_valid || !rr_m);
        wait_e = fb_waitrequest && (sb.size() > 0);
        check("clear_busy", 64'(clear_busy), 64'(busy_e));
        check("src0_full", 64'(src0_full), 64'(busy_e || wait_e || !g0));
        check("src1_full", 64'(src1_full), 64'(busy_e || wait_e || !g1));
        check("clip_count", 64'(clip_count), 64'(clip_m));
        if (!busy_e) begin
            check("fb_write", 64'(fb_write), 64'(sb.size() > 0));
            check("idle", 64'(idle), 64'(sb.size() == 0));
        end else begin
            check("idle_while_busy", 64'(idle), 0);
        end
        if (src0_valid && !src0_full) take(q0.pop_front(), 1'b0);
        if (src1_valid && !src1_full) take(q1.pop_front(), 1'b1);
        if (clear_start && !busy_e) begin
            for (int i = 0; i < NPIX; i++) sb.push_back('{addr: i, col: clear_colour, is_clr: 1'b1});
            clr_rem = NPIX;
        end
    endtask

    // Monitor: whatever is on the bus must be the oldest outstanding expected write
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && fb_write) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(fb_address), 64'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 64'(fb_address), 64'(sb[0].addr));
                    check("wr_data", 64'(fb_writedata), 64'(sb[0].col));
                    if (!fb_waitrequest) begin
                        if (sb[0].is_clr) clr_rem--;
                        void'(sb.pop_front());
                    end
                end
            end
            if (reset_n && lat_cyc == cyc - 1) begin
                check("latency_write", 64'(fb_write), 1);
                check("latency_addr", 64'(fb_address), 64'(lat_addr));
            end
        end
    end

    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // consecutive stream from src0
        q0.push_back(px(0, 0, 32'hC0C0_0000));
        q0.push_back(px(1, 0, 32'hC1C1_0001));
        repeat (4) step(0, 0, 0);

        // both sources contending: grants alternate
        for (int i = 0; i < 4; i++) begin
            q0.push_back(px(i, 1, 32'hA000_0000 + 32'(i)));
            q1.push_back(px(i, 2, 32'hB000_0000 + 32'(i)));
        end
        repeat (10) step(0, 0, 0);

        // clipped pixels on both edges
        q1.push_back(px(H, 3, 32'hDEAD_0001));
        q1.push_back(px(5, V, 32'hDEAD_0002));
        repeat (4) step(0, 0, 0);
        check("clip_two", 64'(clip_count), 2);

        // write held under waitrequest, with a competing pixel stalled behind it
        q0.push_back(px(3, 2, 32'h1234_5678));
        step(0, 0, 0);
        q1.push_back(px(4, 4, 32'h8765_4321));
        repeat (5) step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // fill with a same-cycle pixel, a redundant start and a pixel queued mid-fill
        q0.push_back(px(7, 5, 32'h00FF_00FF));
        step(0, 1, 0);
        for (int i = 0; i < 200 && (clr_rem > 0 || sb.size() > 0 || q0.size() > 0); i++) begin
            if (i == 10) step(2, 1, 0);
            else begin
                if (i == 20) q0.push_back(px(9, 0, 32'h5555_AAAA));
                step(2, 0, 0);
            end
        end
        check("fill_drained", 64'(sb.size()), 0);

        // reset in the middle of a fill
        step(0, 1, 0);
        for (int i = 0; i < 30 && !(fb_write && fb_address == 3); i++) step(0, 0, 0);
        check("fill_reached_addr3", 64'(fb_address), 3);
        step(0, 0, 1);
        repeat (5) step(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() < 2 && $urandom_range(2) != 0) q0.push_back(rand_px());
            if (q1.size() < 2 && $urandom_range(2) != 0) q1.push_back(rand_px());
            step(2, ($urandom_range(199) == 0), 0);
        end

        for (int i = 0; i < 500 && (sb.size() > 0 || clr_rem > 0 || q0.size() > 0 || q1.size() > 0); i++)
            step(0, 0, 0);
        check("drain_outstanding", 64'(sb.size() + q0.size() + q1.size()), 0);
        step(0, 0, 0);
        check("final_idle", 64'(idle), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
